// File: rtl/bullet_pool_pkg.sv
// bullet_pool_pkg
// Shared definitions for the player, enemy and bullet controllers: screen
// geometry, coordinate widths and the bullet parking-position helpers.
// No ports (package).
package bullet_pool_pkg;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int PLAYER_WIDTH = 3;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;

    // Idle bullets sit one pixel right of and one pixel below the player's
    // top-left corner so they are hidden inside the player sprite.
    function automatic logic [X_W-1:0] park_x(input logic [X_W-1:0] player_x);
        return player_x + 8'd1;
    endfunction

    function automatic logic [Y_W-1:0] park_y(input logic [Y_W-1:0] player_y);
        return player_y + 7'd1;
    endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// bullet_pool_if
// Groups the bullet pool's game-side signals.
//   play, load_level, fire       : game control from the player controller
//   playerX, playerY             : player top-left position
//   bullet_hit[NUM_BULLETS]      : per-slot hit flags from enemy collision logic
//   bulletX, bulletY             : packed slot positions (slot i at [8i+7:8i] / [7i+6:7i])
//   active[NUM_BULLETS]          : slot in flight
//   move, fire_ack               : one-cycle event pulses
//   full                         : every slot in flight
// Modports: slave = bullet pool side, master = game/testbench side.
interface bullet_pool_if
    import bullet_pool_pkg::*;
#(
    parameter int NUM_BULLETS = 4
);
    logic                         play;
    logic                         load_level;
    logic                         fire;
    logic [X_W-1:0]               playerX;
    logic [Y_W-1:0]               playerY;
    logic [NUM_BULLETS-1:0]       bullet_hit;
    logic [X_W*NUM_BULLETS-1:0]   bulletX;
    logic [Y_W*NUM_BULLETS-1:0]   bulletY;
    logic [NUM_BULLETS-1:0]       active;
    logic                         move;
    logic                         fire_ack;
    logic                         full;

    modport slave (
        input  play, load_level, fire, playerX, playerY, bullet_hit,
        output bulletX, bulletY, active, move, fire_ack, full
    );

    modport master (
        output play, load_level, fire, playerX, playerY, bullet_hit,
        input  bulletX, bulletY, active, move, fire_ack, full
    );

endinterface

// File: rtl/bullet_pool_slot.sv
// bullet_slot
// One bullet: owns its in-flight flag and its X/Y position.
//   clk, resetn   : clock, synchronous active-low reset
//   clear         : synchronous level restart (same effect as reset)
//   play          : low freezes the slot
//   launch        : start flight from the player's nose this cycle
//   step          : shared step tick; move up one row or retire at the top
//   hit           : enemy collision; retires the slot, beats a step
//   player_x/y    : player top-left position
//   active, x, y  : registered slot state
module bullet_slot
    import bullet_pool_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           clear,
    input  logic           play,
    input  logic           launch,
    input  logic           step,
    input  logic           hit,
    input  logic [X_W-1:0] player_x,
    input  logic [Y_W-1:0] player_y,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y
);

    localparam logic [Y_W-1:0] Y_ONE  = 7'd1;
    localparam logic [Y_W-1:0] Y_ZERO = 7'd0;

    logic           active_r;
    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    logic           active_nx_s;
    logic [X_W-1:0] x_nx_s;
    logic [Y_W-1:0] y_nx_s;

    // Next slot state: hit first, then step/retire, otherwise launch or park.
    always_comb begin
        active_nx_s = active_r;
        x_nx_s      = x_r;
        y_nx_s      = y_r;
        if (play) begin
            if (active_r) begin
                if (hit) begin
                    active_nx_s = 1'b0;
                    x_nx_s      = park_x(player_x);
                    y_nx_s      = park_y(player_y);
                end else if (step) begin
                    if (y_r == Y_ZERO) begin
                        active_nx_s = 1'b0;
                        x_nx_s      = park_x(player_x);
                        y_nx_s      = park_y(player_y);
                    end else begin
                        y_nx_s = y_r - Y_ONE;
                    end
                end else begin
                    y_nx_s = y_r;
                end
            end else if (launch) begin
                // Launch starts on the player's top row, not the park row.
                active_nx_s = 1'b1;
                x_nx_s      = park_x(player_x);
                y_nx_s      = player_y;
            end else begin
                x_nx_s = park_x(player_x);
                y_nx_s = park_y(player_y);
            end
        end else begin
            active_nx_s = active_r;
        end
    end

    // Slot state register with synchronous reset to the parked position.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            active_r <= 1'b0;
            x_r      <= park_x(player_x);
            y_r      <= park_y(player_y);
        end else begin
            active_r <= active_nx_s;
            x_r      <= x_nx_s;
            y_r      <= y_nx_s;
        end
    end

    assign active = active_r;
    assign x      = x_r;
    assign y      = y_r;

endmodule

// File: rtl/bullet_pool.sv
// bullet_pool
// Multi-slot player projectile controller. NUM_BULLETS slots share one step
// timer; new shots go to the lowest free slot, subject to a fire cooldown.
// Ports:
//   clk     : system clock
//   resetn  : synchronous active-low reset
//   bus     : bullet_pool_if.slave (game control, player position, per-slot
//             hits in; packed positions, active, move, fire_ack, full out)
// Parameters: NUM_BULLETS (1..8), RATE_DIV (step every RATE_DIV+1 clocks),
//             COOLDOWN (min clocks between launches, 0 = no limit).
// Build option: define BULLET_AUTOFIRE_EN to fire on the fire level instead
// of its rising edge.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int          NUM_BULLETS = 4,
    parameter logic [27:0] RATE_DIV    = 28'd500000,
    parameter int          COOLDOWN    = 16
)(
    input  logic clk,
    input  logic resetn,
    bullet_pool_if.slave bus
);

    localparam int TICK_W = (RATE_DIV == 28'd0) ? 1 : $clog2(RATE_DIV + 29'd1);
    localparam int CD_W   = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    localparam logic [TICK_W-1:0]      TICK_MAX  = TICK_W'(RATE_DIV);
    localparam logic [TICK_W-1:0]      TICK_ONE  = TICK_W'(1'b1);
    localparam logic [TICK_W-1:0]      TICK_ZERO = TICK_W'(1'b0);
    localparam logic [CD_W-1:0]        CD_ONE    = CD_W'(1'b1);
    localparam logic [CD_W-1:0]        CD_ZERO   = CD_W'(1'b0);
    // The launch clock is the first of the COOLDOWN blocked clocks, so a
    // request arriving COOLDOWN clocks after a launch is accepted.
    localparam logic [CD_W-1:0]        CD_LOAD   = (COOLDOWN > 1) ? CD_W'(COOLDOWN - 1) : CD_ZERO;
    localparam logic [NUM_BULLETS-1:0] SLOT_ONE  = NUM_BULLETS'(1'b1);
    localparam logic [NUM_BULLETS-1:0] SLOT_NONE = NUM_BULLETS'(1'b0);

    logic [TICK_W-1:0]          tick_r;
    logic [CD_W-1:0]            cd_r;
    logic                       fire_q_r;
    logic                       move_r;
    logic                       fire_ack_r;

    logic                       clear_s;
    logic                       req_s;
    logic                       accept_s;
    logic                       step_s;
    logic [NUM_BULLETS-1:0]     active_s;
    logic [NUM_BULLETS-1:0]     lowest_free_s;
    logic [NUM_BULLETS-1:0]     launch_s;
    logic [X_W*NUM_BULLETS-1:0] x_pack_s;
    logic [Y_W*NUM_BULLETS-1:0] y_pack_s;

    assign clear_s = !resetn || bus.load_level;

    // Fire request, launch decision and shared step tick.
    always_comb begin
`ifdef BULLET_AUTOFIRE_EN
        req_s = bus.fire;
`else
        req_s = bus.fire && !fire_q_r;
`endif
        accept_s = req_s && bus.play && (cd_r == CD_ZERO) && !(&active_s);
        step_s   = bus.play && (|active_s) && (tick_r == TICK_MAX);
        // Adding one carries through the trailing ones, so the AND with the
        // inverse keeps only the lowest zero bit of the registered active.
        lowest_free_s = ~active_s & (active_s + SLOT_ONE);
        if (accept_s) begin
            launch_s = lowest_free_s;
        end else begin
            launch_s = SLOT_NONE;
        end
    end

    // Step timer, cooldown, fire edge history and event pulses.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            tick_r     <= TICK_ZERO;
            cd_r       <= CD_ZERO;
            fire_q_r   <= 1'b0;
            move_r     <= 1'b0;
            fire_ack_r <= 1'b0;
        end else begin
            // Sampled even when paused so resuming never creates an edge.
            fire_q_r   <= bus.fire;
            move_r     <= step_s;
            fire_ack_r <= accept_s;
            if (bus.play) begin
                if (!(|active_s) || (tick_r == TICK_MAX)) begin
                    tick_r <= TICK_ZERO;
                end else begin
                    tick_r <= tick_r + TICK_ONE;
                end
                if (accept_s) begin
                    cd_r <= CD_LOAD;
                end else if (cd_r != CD_ZERO) begin
                    cd_r <= cd_r - CD_ONE;
                end else begin
                    cd_r <= CD_ZERO;
                end
            end else begin
                tick_r <= tick_r;
                cd_r   <= cd_r;
            end
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot u_slot (
            .clk      (clk),
            .resetn   (resetn),
            .clear    (bus.load_level),
            .play     (bus.play),
            .launch   (launch_s[g]),
            .step     (step_s),
            .hit      (bus.bullet_hit[g]),
            .player_x (bus.playerX),
            .player_y (bus.playerY),
            .active   (active_s[g]),
            .x        (x_pack_s[X_W*g +: X_W]),
            .y        (y_pack_s[Y_W*g +: Y_W])
        );
    end

    assign bus.bulletX  = x_pack_s;
    assign bus.bulletY  = y_pack_s;
    assign bus.active   = active_s;
    assign bus.move     = move_r;
    assign bus.fire_ack = fire_ack_r;
    assign bus.full     = &active_s;

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool
// Directed scenarios followed by random play, every cycle compared against a
// behavioural model of the bullet rules (3 slots, step every 4 clocks,
// 4-clock fire spacing).
module tb_bullet_pool;

    localparam int N  = 3;
    localparam int RD = 3;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic resetn;

    bullet_pool_if #(.NUM_BULLETS(N)) bus ();

    bullet_pool #(
        .NUM_BULLETS (N),
        .RATE_DIV    (28'd3),
        .COOLDOWN    (CD)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    bit         m_act [N];
    logic [7:0] m_x   [N];
    logic [6:0] m_y   [N];
    int         m_ph;     // active clocks since the step phase began
    int         m_gap;    // play clocks since the last launch (saturates at CD)
    bit         m_fq;
    bit         m_ack;
    bit         m_mv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the bullet rules for one clock edge using the pre-edge inputs.
    task automatic model_edge();
        bit req, any, stp, ok;
        int free;
        if (!resetn || bus.load_level) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 1'b0;
                m_x[i]   = bus.playerX + 8'd1;
                m_y[i]   = bus.playerY + 7'd1;
            end
            m_ph = 0; m_gap = CD; m_fq = 1'b0; m_ack = 1'b0; m_mv = 1'b0;
        end else begin
`ifdef BULLET_AUTOFIRE_EN
            req = bus.fire;
`else
            req = bus.fire && !m_fq;
`endif
            m_fq = bus.fire;
            m_ack = 1'b0; m_mv = 1'b0;
            if (bus.play) begin
                any = 1'b0; free = -1;
                for (int i = 0; i < N; i++) begin
                    if (m_act[i]) any = 1'b1;
                    else if (free < 0) free = i;
                end
                stp = any && ((m_ph % (RD + 1)) == RD);
                ok  = req && (m_gap >= CD) && (free >= 0);
                for (int i = 0; i < N; i++) begin
                    if (m_act[i]) begin
                        if (bus.bullet_hit[i] || (stp && m_y[i] == 7'd0)) begin
                            m_act[i] = 1'b0;
                            m_x[i]   = bus.playerX + 8'd1;
                            m_y[i]   = bus.playerY + 7'd1;
                        end else if (stp) begin
                            m_y[i] = m_y[i] - 7'd1;
                        end
                    end else if (ok && i == free) begin
                        m_act[i] = 1'b1;
                        m_x[i]   = bus.playerX + 8'd1;
                        m_y[i]   = bus.playerY;
                    end else begin
                        m_x[i] = bus.playerX + 8'd1;
                        m_y[i] = bus.playerY + 7'd1;
                    end
                end
                m_ph  = any ? m_ph + 1 : 0;
                m_gap = ok ? 1 : ((m_gap < CD) ? m_gap + 1 : CD);
                m_ack = ok;
                m_mv  = stp;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] ex_x, ex_y, ex_a;
        logic        ex_full;
        ex_x = 64'd0; ex_y = 64'd0; ex_a = 64'd0; ex_full = 1'b1;
        for (int i = 0; i < N; i++) begin
            ex_x[8*i +: 8] = m_x[i];
            ex_y[7*i +: 7] = m_y[i];
            ex_a[i]        = m_act[i];
            ex_full        = ex_full & m_act[i];
        end
        check("active",   64'(bus.active),   ex_a);
        check("bulletX",  64'(bus.bulletX),  ex_x);
        check("bulletY",  64'(bus.bulletY),  ex_y);
        check("move",     64'(bus.move),     64'(m_mv));
        check("fire_ack", 64'(bus.fire_ack), 64'(m_ack));
        check("full",     64'(bus.full),     64'(ex_full));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic fire_pulse(input int idle);
        bus.fire = 1'b1;
        cycle();
        bus.fire = 1'b0;
        for (int k = 0; k < idle; k++) cycle();
    endtask

    initial begin
        bit   aligned;
        resetn         = 1'b0;
        bus.play       = 1'b1;
        bus.load_level = 1'b0;
        bus.fire       = 1'b0;
        bus.playerX    = 8'd80;
        bus.playerY    = 7'd115;
        bus.bullet_hit = 3'b000;

        // Reset state
        cycle(); cycle();
        check("rst_active", 64'(bus.active), 64'd0);
        check("rst_x0", 64'(bus.bulletX[7:0]), 64'd81);
        check("rst_y0", 64'(bus.bulletY[6:0]), 64'd116);
        check("rst_ack", 64'(bus.fire_ack), 64'd0);
        resetn = 1'b1;
        cycle();

        // Allocation: slots fill lowest first, extra press is dropped
        bus.fire = 1'b1; cycle(); bus.fire = 1'b0;
        check("alloc_ack0", 64'(bus.fire_ack), 64'd1);
        check("alloc_x0", 64'(bus.bulletX[7:0]), 64'd81);
        check("alloc_y0", 64'(bus.bulletY[6:0]), 64'd115);
        for (int k = 0; k < 4; k++) cycle();
        bus.fire = 1'b1; cycle(); bus.fire = 1'b0;
        check("alloc_act1", 64'(bus.active), 64'd3);
        check("alloc_y1", 64'(bus.bulletY[13:7]), 64'd115);
        for (int k = 0; k < 4; k++) cycle();
        fire_pulse(4);
        check("alloc_full", 64'(bus.full), 64'd1);
        bus.fire = 1'b1; cycle(); bus.fire = 1'b0;
        check("alloc_noack", 64'(bus.fire_ack), 64'd0);
        cycle();

        // Cooldown: edge 2 clocks after a launch rejected, 4 clocks accepted
        bus.load_level = 1'b1; cycle(); bus.load_level = 1'b0;
        bus.fire = 1'b1; cycle(); bus.fire = 1'b0; cycle();
        bus.fire = 1'b1; cycle(); bus.fire = 1'b0;
        check("cd_reject", 64'(bus.fire_ack), 64'd0);
        cycle();
        bus.fire = 1'b1; cycle(); bus.fire = 1'b0;
        check("cd_accept", 64'(bus.fire_ack), 64'd1);
        cycle();

        // Reset mid-flight
        resetn = 1'b0; cycle();
        check("midrst_act", 64'(bus.active), 64'd0);
        check("midrst_y0", 64'(bus.bulletY[6:0]), 64'd116);
        resetn = 1'b1; cycle();

        // Step and retire from a low launch row
        bus.playerX = 8'd10; bus.playerY = 7'd2;
        bus.fire = 1'b1; cycle(); bus.fire = 1'b0;
        check("step_launch_y", 64'(bus.bulletY[6:0]), 64'd2);
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c == 4) check("step_y1", 64'(bus.bulletY[6:0]), 64'd1);
            if (c == 8) check("step_y0", 64'(bus.bulletY[6:0]), 64'd0);
        end
        check("retire_act", 64'(bus.active), 64'd0);
        check("retire_move", 64'(bus.move), 64'd1);

        // Hit on the same edge as a step
        bus.playerY = 7'd100;
        fire_pulse(4);
        fire_pulse(0);
        aligned = 1'b0;
        for (int k = 0; k < 8 && !aligned; k++) begin
            if ((m_ph % (RD + 1)) == RD) aligned = 1'b1;
            else cycle();
        end
        bus.bullet_hit = 3'b010; cycle(); bus.bullet_hit = 3'b000;
        check("hit_act1", 64'(bus.active[1]), 64'd0);
        check("hit_park_y1", 64'(bus.bulletY[13:7]), 64'd101);
        check("hit_move", 64'(bus.move), 64'd1);
        cycle();

        // Pause with fire toggling, then resume with fire held
        bus.play = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.fire = c[0];
            bus.playerX = bus.playerX + 8'd1;
            cycle();
        end
        bus.play = 1'b1; bus.fire = 1'b1;
        for (int c = 0; c < 20; c++) cycle();
        bus.fire = 1'b0; cycle();

        // Random play
        for (int c = 0; c < 4000; c++) begin
            resetn         = ($urandom_range(0, 299) != 0);
            bus.load_level = ($urandom_range(0, 399) == 0);
            bus.play       = ($urandom_range(0, 9) != 0);
            bus.fire       = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) bus.bullet_hit[i] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.playerX = 8'($urandom_range(0, 255));
                bus.playerY = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 6))
                                                          : 7'($urandom_range(0, 119));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
